// File: rtl/tap_loader_if.sv
// tap_loader_if: ioctl download stream from hps_io plus the write port toward the RAM arbiter.
// The loader sits on the slave side; the master side is hps_io together with the arbiter.
interface tap_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wait;
    logic        mem_req;
    logic        mem_gnt;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_data, mem_gnt,
        input  ioctl_wait, mem_req, mem_addr, mem_data
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_data, mem_gnt,
        output ioctl_wait, mem_req, mem_addr, mem_data
    );
endinterface

// File: rtl/tap_loader.sv
// tap_loader: parses a KC85/4 TAP download and writes its payload into main memory.
// Define TAP_AUTOSTART_EN to emit an exec_req pulse with the parsed start address.
module tap_loader #(
    parameter logic [7:0] TAP_INDEX = 8'd1
) (
    input  logic        clk_sys,
    input  logic        reset,
    tap_loader_if.slave bus,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        exec_req,
    output logic [15:0] exec_addr
);
    typedef enum logic [2:0] {IDLE, FHDR, BLKNUM, KCCHDR, DATA, WRITE, DONE, ERROR} state_t;

    state_t      state_reg, state_next;
    logic [6:0]  pos_reg, pos_next;
    logic        first_blk_reg, first_blk_next;
    logic        last_reg, last_next;
    logic [7:0]  args_reg, args_next;
    logic [15:0] load_reg, load_next;
    logic [15:0] end_reg, end_next;
    logic [15:0] start_reg, start_next;
    logic [15:0] cur_reg, cur_next;
    logic [15:0] mem_addr_reg, mem_addr_next;
    logic [7:0]  mem_data_reg, mem_data_next;
    logic        mem_req_reg, wait_reg, busy_reg, done_reg, error_reg;
    logic        dl_prev_reg;

    logic byte_wr, dl_start;
    assign byte_wr  = bus.ioctl_wr && (bus.ioctl_index == TAP_INDEX);
    assign dl_start = bus.ioctl_download && (bus.ioctl_index == TAP_INDEX);

    always_comb begin
        state_next     = state_reg;
        pos_next       = pos_reg;
        first_blk_next = first_blk_reg;
        last_next      = last_reg;
        args_next      = args_reg;
        load_next      = load_reg;
        end_next       = end_reg;
        start_next     = start_reg;
        cur_next       = cur_reg;
        mem_addr_next  = mem_addr_reg;
        mem_data_next  = mem_data_reg;
        case (state_reg)
            IDLE: begin
                if (dl_start) begin
                    state_next     = FHDR;
                    pos_next       = 7'd0;
                    first_blk_next = 1'b1;
                end
            end
            DONE, ERROR: begin
                if (dl_start && !dl_prev_reg) begin
                    state_next     = FHDR;
                    pos_next       = 7'd0;
                    first_blk_next = 1'b1;
                end
            end
            WRITE: begin
                // Stray ioctl_wr strobes here are ignored; hps_io is stalled by ioctl_wait.
                if (bus.mem_gnt) begin
                    cur_next = cur_reg + 16'd1;
                    if (!bus.ioctl_download)
                        state_next = ERROR;
                    else if (last_reg)
                        state_next = BLKNUM;
                    else
                        state_next = DATA;
                end
            end
            default: begin
                if (byte_wr && bus.ioctl_addr == 25'd0) begin
                    // Offset 0 always carries the magic byte, so it restarts header parsing.
                    pos_next       = 7'd1;
                    first_blk_next = 1'b1;
                    state_next     = (bus.ioctl_data == 8'hC3) ? FHDR : ERROR;
                end else if (!bus.ioctl_download) begin
                    if ((state_reg == DATA || state_reg == BLKNUM) && cur_reg == end_reg)
                        state_next = DONE;
                    else
                        state_next = ERROR;
                end else if (byte_wr) begin
                    case (state_reg)
                        FHDR: begin
                            pos_next = pos_reg + 7'd1;
                            if (pos_reg == 7'd0 && bus.ioctl_data != 8'hC3)
                                state_next = ERROR;
                            else if (pos_reg == 7'd15)
                                state_next = BLKNUM;
                        end
                        BLKNUM: begin
                            pos_next   = 7'd0;
                            state_next = first_blk_reg ? KCCHDR : DATA;
                        end
                        KCCHDR: begin
                            pos_next = pos_reg + 7'd1;
                            case (pos_reg)
                                7'd16: args_next        = bus.ioctl_data;
                                7'd17: load_next[7:0]   = bus.ioctl_data;
                                7'd18: load_next[15:8]  = bus.ioctl_data;
                                7'd19: end_next[7:0]    = bus.ioctl_data;
                                7'd20: end_next[15:8]   = bus.ioctl_data;
                                7'd21: start_next[7:0]  = bus.ioctl_data;
                                7'd22: start_next[15:8] = bus.ioctl_data;
                                default: ;
                            endcase
                            if (pos_reg == 7'd127) begin
                                cur_next       = load_reg;
                                first_blk_next = 1'b0;
                                state_next     = BLKNUM;
                            end
                        end
                        DATA: begin
                            pos_next = pos_reg + 7'd1;
                            if (cur_reg != end_reg) begin
                                mem_addr_next = cur_reg;
                                mem_data_next = bus.ioctl_data;
                                last_next     = (pos_reg == 7'd127);
                                state_next    = WRITE;
                            end else if (pos_reg == 7'd127) begin
                                state_next = BLKNUM;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg     <= IDLE;
            pos_reg       <= 7'd0;
            first_blk_reg <= 1'b0;
            last_reg      <= 1'b0;
            args_reg      <= 8'd0;
            load_reg      <= 16'd0;
            end_reg       <= 16'd0;
            start_reg     <= 16'd0;
            cur_reg       <= 16'd0;
            mem_addr_reg  <= 16'd0;
            mem_data_reg  <= 8'd0;
            mem_req_reg   <= 1'b0;
            wait_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
            dl_prev_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pos_reg       <= pos_next;
            first_blk_reg <= first_blk_next;
            last_reg      <= last_next;
            args_reg      <= args_next;
            load_reg      <= load_next;
            end_reg       <= end_next;
            start_reg     <= start_next;
            cur_reg       <= cur_next;
            mem_addr_reg  <= mem_addr_next;
            mem_data_reg  <= mem_data_next;
            mem_req_reg   <= (state_next == WRITE);
            wait_reg      <= (state_next == WRITE);
            busy_reg      <= !(state_next == IDLE || state_next == DONE || state_next == ERROR);
            done_reg      <= (state_next == DONE);
            error_reg     <= (state_next == ERROR);
            dl_prev_reg   <= bus.ioctl_download;
        end
    end

`ifdef TAP_AUTOSTART_EN
    logic        exec_req_reg;
    logic [15:0] exec_addr_reg;
    logic        done_entry;
    assign done_entry = (state_next == DONE) && (state_reg != DONE);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            exec_req_reg  <= 1'b0;
            exec_addr_reg <= 16'd0;
        end else begin
            exec_req_reg <= done_entry && (args_reg >= 8'd3);
            if (done_entry)
                exec_addr_reg <= (args_reg >= 8'd3) ? start_reg : 16'd0;
        end
    end

    assign exec_req  = exec_req_reg;
    assign exec_addr = exec_addr_reg;
`else
    logic unused_parse;
    assign unused_parse = ^{start_reg, args_reg};
    assign exec_req     = 1'b0;
    assign exec_addr    = 16'd0;
`endif

    assign bus.ioctl_wait = wait_reg;
    assign bus.mem_req    = mem_req_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_data   = mem_data_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign error          = error_reg;
endmodule

// File: tb/tb_tap_loader.sv
// tb_tap_loader: scoreboard bench for tap_loader; TAP images are built here and the expected
// memory writes are queued as each image is built, then popped as the DUT writes.
module tb_tap_loader;
    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        busy, done, error, exec_req;
    logic [15:0] exec_addr;

    tap_loader_if bus();

    tap_loader dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .exec_req (exec_req),
        .exec_addr(exec_addr)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;
    logic [7:0]  file_q[$];
    logic [23:0] exp_q[$];
    logic [23:0] exp_w;
    int write_cnt, req_cycles, wait_cycles, wait_run, max_run, exec_pulses;
    int stall_left = 0;
    logic [15:0] last_wr_addr, exec_seen;
    logic        prev_req = 1'b0, prev_wr = 1'b0;
    logic [15:0] prev_addr;
    logic [7:0]  prev_data;

    initial begin
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = 25'd0;
        bus.ioctl_data     = 8'd0;
        bus.mem_gnt        = 1'b1;
    end

    // Arbiter model: grant immediately unless a stall budget is pending.
    initial begin
        forever begin
            @(posedge clk_sys); #1;
            if (bus.mem_req === 1'b1 && stall_left > 0) begin
                bus.mem_gnt = 1'b0;
                stall_left--;
            end else begin
                bus.mem_gnt = 1'b1;
            end
        end
    end

    // Monitor on the falling edge: mem_req && mem_gnt here means a write at the next rising edge.
    initial begin
        forever begin
            @(negedge clk_sys);
            if (bus.mem_req === 1'b1) req_cycles++;
            if (bus.ioctl_wait === 1'b1) begin
                wait_cycles++;
                wait_run++;
                if (wait_run > max_run) max_run = wait_run;
            end else begin
                wait_run = 0;
            end
            if (exec_req === 1'b1) begin
                exec_pulses++;
                exec_seen = exec_addr;
            end
            if (bus.ioctl_wr === 1'b1 && bus.ioctl_wait === 1'b1) begin
                checks++; errors++;
                $display("FAIL protocol: ioctl_wr seen while ioctl_wait=1");
            end
            if (bus.mem_req === 1'b1 && prev_req && !prev_wr) begin
                checks++;
                if (bus.mem_addr !== prev_addr || bus.mem_data !== prev_data) begin
                    errors++;
                    $display("FAIL req_stable: addr/data %h/%h changed from %h/%h before grant",
                             bus.mem_addr, bus.mem_data, prev_addr, prev_data);
                end
            end
            if (bus.mem_req === 1'b1 && bus.mem_gnt === 1'b1) begin
                write_cnt++;
                last_wr_addr = bus.mem_addr;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: addr=%h data=%h, none required",
                             bus.mem_addr, bus.mem_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({bus.mem_addr, bus.mem_data} !== exp_w) begin
                        errors++;
                        $display("FAIL write_data: got addr=%h data=%h want addr=%h data=%h",
                                 bus.mem_addr, bus.mem_data, exp_w[23:8], exp_w[7:0]);
                    end else begin
                        $display("write addr=%h data=%h", bus.mem_addr, bus.mem_data);
                    end
                end
            end
            prev_req  = (bus.mem_req === 1'b1);
            prev_wr   = (bus.mem_req === 1'b1 && bus.mem_gnt === 1'b1);
            prev_addr = bus.mem_addr;
            prev_data = bus.mem_data;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    task automatic clear_stats();
        write_cnt = 0; req_cycles = 0; wait_cycles = 0; wait_run = 0;
        max_run = 0; exec_pulses = 0; exec_seen = 16'd0;
    endtask

    task automatic build_tap(input logic [7:0] magic, input logic [15:0] load,
                             input logic [15:0] end_a, input logic [15:0] start,
                             input logic [7:0] args, input int nblk);
        logic [15:0] cur;
        logic [7:0]  b;
        file_q.delete();
        exp_q.delete();
        file_q.push_back(magic);
        for (int i = 1; i < 16; i++) file_q.push_back(8'h20 + 8'(i));
        file_q.push_back(8'h01);
        for (int i = 0; i < 128; i++) begin
            case (i)
                16: b = args;
                17: b = load[7:0];
                18: b = load[15:8];
                19: b = end_a[7:0];
                20: b = end_a[15:8];
                21: b = start[7:0];
                22: b = start[15:8];
                default: b = (i < 8) ? 8'h41 + 8'(i) : 8'h00;
            endcase
            file_q.push_back(b);
        end
        cur = load;
        for (int k = 0; k < nblk; k++) begin
            file_q.push_back(8'(k + 2));
            for (int i = 0; i < 128; i++) begin
                b = 8'((k * 128 + i) * 13 + 8'h5A);
                file_q.push_back(b);
                if (cur != end_a) begin
                    exp_q.push_back({cur, b});
                    cur = cur + 16'd1;
                end
            end
        end
    endtask

    task automatic send_byte(input int a, input logic [7:0] d);
        int n;
        n = 0;
        while (bus.ioctl_wait === 1'b1 && n < 2000) begin
            @(posedge clk_sys); #1;
            n++;
        end
        if (n >= 2000) begin
            checks++; errors++;
            $display("FAIL send_timeout: ioctl_wait still 1 at offset %0d, want 0", a);
        end
        bus.ioctl_addr = 25'(a);
        bus.ioctl_data = d;
        bus.ioctl_wr   = 1'b1;
        @(posedge clk_sys); #1;
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic start_download();
        bus.ioctl_index    = 8'd1;
        bus.ioctl_download = 1'b1;
        @(posedge clk_sys); #1;
    endtask

    task automatic end_download();
        @(posedge clk_sys); #1;
        bus.ioctl_download = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_file(input string name);
        start_download();
        for (int i = 0; i < file_q.size(); i++) send_byte(i, file_q[i]);
        end_download();
        $display("file %s: %0d bytes sent, %0d writes, done=%0b error=%0b",
                 name, file_q.size(), write_cnt, done, error);
    endtask

    task automatic check_done(input string name, input int want_writes);
        checks++;
        if (write_cnt !== want_writes) begin
            errors++;
            $display("FAIL %s_writes: got %0d want %0d", name, write_cnt, want_writes);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: %0d writes outstanding, want 0", name, exp_q.size());
        end
        checks++;
        if ({done, busy, error} !== 3'b100) begin
            errors++;
            $display("FAIL %s_status: done/busy/error=%b want 100", name, {done, busy, error});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        checks++; if (bus.ioctl_wait !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b want 0", bus.ioctl_wait); end
        checks++; if ({busy, done, error, exec_req} !== 4'b0000) begin errors++; $display("FAIL reset_status: busy/done/error/exec_req=%b want 0000", {busy, done, error, exec_req}); end
        checks++; if (bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr: got %h want 0000", bus.mem_addr); end
        checks++; if (bus.mem_data !== 8'h00) begin errors++; $display("FAIL reset_mem_data: got %h want 00", bus.mem_data); end
        checks++; if (exec_addr !== 16'h0000) begin errors++; $display("FAIL reset_exec_addr: got %h want 0000", exec_addr); end
        reset = 1'b0;
        @(posedge clk_sys); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_block();
        clear_stats();
        build_tap(8'hC3, 16'h0300, 16'h0380, 16'h0300, 8'd2, 1);
        send_file("single_block");
        check_done("single_block", 128);
        checks++; if (last_wr_addr !== 16'h037F) begin errors++; $display("FAIL single_last_addr: got %h want 037F", last_wr_addr); end
        checks++; if (max_run !== 1) begin errors++; $display("FAIL single_wait_run: got %0d want 1", max_run); end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        build_tap(8'hC3, 16'h1000, 16'h10F0, 16'h1000, 8'd2, 2);
        stall_left = 10;
        send_file("stall_two_blocks");
        check_done("stall", 240);
        checks++; if (max_run !== 11) begin errors++; $display("FAIL stall_wait_run: got %0d want 11", max_run); end
        checks++; if (wait_cycles !== 250) begin errors++; $display("FAIL stall_wait_cycles: got %0d want 250", wait_cycles); end
        checks++; if (req_cycles !== 250) begin errors++; $display("FAIL stall_req_cycles: got %0d want 250", req_cycles); end
    endtask

    task automatic test_bad_magic();
        clear_stats();
        build_tap(8'h00, 16'h0300, 16'h0310, 16'h0300, 8'd2, 1);
        start_download();
        send_byte(0, file_q[0]);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL magic_error: got %b want 1", error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL magic_busy: got %b want 0", busy); end
        for (int i = 1; i < 20; i++) send_byte(i, file_q[i]);
        end_download();
        checks++; if (req_cycles !== 0) begin errors++; $display("FAIL magic_mem_req: %0d request cycles, want 0", req_cycles); end
        checks++; if ({done, error} !== 2'b01) begin errors++; $display("FAIL magic_held: done/error=%b want 01", {done, error}); end
        exp_q.delete();
        $display("file bad_magic: error=%0b", error);
    endtask

    task automatic test_wrap();
        clear_stats();
        build_tap(8'hC3, 16'hFFF0, 16'h0010, 16'hFFF0, 8'd2, 1);
        send_file("wrap");
        check_done("wrap", 32);
        checks++; if (last_wr_addr !== 16'h000F) begin errors++; $display("FAIL wrap_last_addr: got %h want 000F", last_wr_addr); end
        checks++; if (wait_cycles !== 32) begin errors++; $display("FAIL wrap_wait_cycles: got %0d want 32", wait_cycles); end
    endtask

    task automatic test_truncated();
        clear_stats();
        build_tap(8'hC3, 16'h3000, 16'h3100, 16'h3000, 8'd2, 1);
        send_file("truncated");
        checks++; if (write_cnt !== 128) begin errors++; $display("FAIL trunc_writes: got %0d want 128", write_cnt); end
        checks++; if ({done, busy, error} !== 3'b001) begin errors++; $display("FAIL trunc_status: done/busy/error=%b want 001", {done, busy, error}); end
        exp_q.delete();
    endtask

    task automatic test_reset_in_write();
        int n;
        clear_stats();
        build_tap(8'hC3, 16'h2000, 16'h2010, 16'h2000, 8'd2, 1);
        stall_left = 100000;
        start_download();
        for (int i = 0; i <= 146; i++) send_byte(i, file_q[i]);
        n = 0;
        while (bus.mem_req !== 1'b1 && n < 10) begin @(posedge clk_sys); #1; n++; end
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rstw_req: got %b want 1", bus.mem_req); end
        reset = 1'b1;
        bus.ioctl_download = 1'b0;
        @(posedge clk_sys); #1;
        checks++; if ({bus.mem_req, bus.ioctl_wait} !== 2'b00) begin errors++; $display("FAIL rstw_req_wait: mem_req/wait=%b want 00", {bus.mem_req, bus.ioctl_wait}); end
        checks++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL rstw_status: busy/done/error=%b want 000", {busy, done, error}); end
        reset = 1'b0;
        stall_left = 0;
        repeat (3) @(posedge clk_sys);
        #1;
        checks++; if (write_cnt !== 0) begin errors++; $display("FAIL rstw_no_write: got %0d writes want 0", write_cnt); end
        checks++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL rstw_idle: busy/done/error=%b want 000", {busy, done, error}); end
        clear_stats();
        build_tap(8'hC3, 16'h2000, 16'h2010, 16'h2000, 8'd2, 1);
        send_file("after_reset");
        check_done("after_reset", 16);
    endtask

    task automatic test_autostart();
        clear_stats();
        build_tap(8'hC3, 16'h0500, 16'h0508, 16'h0400, 8'd3, 1);
        send_file("autostart_args3");
        check_done("auto3", 8);
`ifdef TAP_AUTOSTART_EN
        checks++; if (exec_pulses !== 1) begin errors++; $display("FAIL auto3_pulse: got %0d cycles want 1", exec_pulses); end
        checks++; if (exec_seen !== 16'h0400) begin errors++; $display("FAIL auto3_addr: got %h want 0400", exec_seen); end
        clear_stats();
        build_tap(8'hC3, 16'h0500, 16'h0508, 16'h0400, 8'd2, 1);
        send_file("autostart_args2");
        check_done("auto2", 8);
        checks++; if (exec_pulses !== 0) begin errors++; $display("FAIL auto2_pulse: got %0d cycles want 0", exec_pulses); end
        checks++; if (exec_addr !== 16'h0000) begin errors++; $display("FAIL auto2_addr: got %h want 0000", exec_addr); end
`else
        checks++; if (exec_pulses !== 0) begin errors++; $display("FAIL noauto_pulse: got %0d cycles want 0", exec_pulses); end
        checks++; if (exec_addr !== 16'h0000) begin errors++; $display("FAIL noauto_addr: got %h want 0000", exec_addr); end
`endif
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_single_block();
        test_back_to_back();
        test_bad_magic();
        test_wrap();
        test_truncated();
        test_reset_in_write();
        test_autostart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
